// File: rtl/bf16_pkg.sv
// rtl/bf16_pkg.sv - shared bf16 format constants and packed value type
package bf16_pkg;

    localparam int E    = 8;
    localparam int M    = 7;
    localparam int BIAS = 127;

    localparam logic [E-1:0] EXP_MAX   = {E{1'b1}};
    localparam logic [M-1:0] QNAN_FRAC = M'(1) << (M - 1);

    typedef struct packed {
        logic         s;
        logic [E-1:0] e;
        logic [M-1:0] m;
    } bf16_t;

endpackage

// File: rtl/bf16_lzc.sv
// rtl/bf16_lzc.sv - combinational leading-zero counter
//
// Ports:
//   d        in   W   vector to scan, MSB first
//   count    out  CW  number of leading zeros (W when d is zero)
//   all_zero out  1   d is entirely zero
module bf16_lzc
    import bf16_pkg::*;
#(
    parameter int W  = bf16_pkg::M + 4,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  d,
    output logic [CW-1:0] count,
    output logic          all_zero
);

    // Scan upward so the highest set bit is the last one to overwrite count.
    always_comb begin
        count    = CW'(W);
        all_zero = 1'b1;
        for (int i = 0; i < W; i++) begin
            if (d[i]) begin
                count    = CW'(W - 1 - i);
                all_zero = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bf16_round_norm.sv
// rtl/bf16_round_norm.sv - two-stage normalize / round-to-nearest-even / pack for bf16 sums
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   valid_i, ready_o       input handshake
//   s_i, e_i, m_i          raw sum: sign, biased exponent, {carry, hidden, frac, g, r, st}
//   nan_i, inf_i           special-value markers from the adder
//   valid_o, ready_i       output handshake
//   s_o, e_o, m_o          packed bf16 result
//   overflow_o             finite value became infinity
//   underflow_o            nonzero value flushed to zero
//   inexact_o              guard/round/sticky bits were discarded
module bf16_round_norm
    import bf16_pkg::*;
#(
    parameter int E    = bf16_pkg::E,
    parameter int M    = bf16_pkg::M,
    parameter int BIAS = bf16_pkg::BIAS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic         s_i,
    input  logic [E-1:0] e_i,
    input  logic [M+4:0] m_i,
    input  logic         nan_i,
    input  logic         inf_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic         s_o,
    output logic [E-1:0] e_o,
    output logic [M-1:0] m_o,
    output logic         overflow_o,
    output logic         underflow_o,
    output logic         inexact_o
);

    localparam int MW = M + 5;           // raw mantissa incl. carry
    localparam int NW = M + 4;           // normalized {1, frac, g, r, st}
    localparam int XW = E + 2;           // signed exponent workspace
    localparam int CW = $clog2(NW + 1);

    // Largest biased exponent is 2*BIAS+1, which is the all-ones code.
    localparam logic [E-1:0]  EXP_ONES = E'(2 * BIAS + 1);
    localparam logic [XW-1:0] EXP_LIM  = XW'(2 * BIAS + 1);
    localparam logic [M-1:0]  QNAN     = M'(1) << (M - 1);

    logic en1, en2;
    logic v1;

    assign en2     = ~valid_o | ready_i;
    assign en1     = ~v1 | en2;
    assign ready_o = en1;

    // ---------------- stage 1: normalize ----------------
    logic [CW-1:0] lz;
    logic          lz_zero;

    bf16_lzc #(.W(NW), .CW(CW)) u_lzc (
        .d        (m_i[NW-1:0]),
        .count    (lz),
        .all_zero (lz_zero)
    );

    logic [XW-1:0] exp_n;
    logic [NW-1:0] mant_n;
    logic          zero_n;
    logic          flush_n;

    always_comb begin
        exp_n  = '0;
        mant_n = '0;
        if (m_i[MW-1]) begin
            // Carry out of the adder: drop one bit into sticky.
            mant_n = {m_i[MW-1:2], m_i[1] | m_i[0]};
            exp_n  = {2'b00, e_i} + XW'(1);
        end else begin
            mant_n = m_i[NW-1:0] << lz;
            exp_n  = {2'b00, e_i} - {{(XW-CW){1'b0}}, lz};
        end
        zero_n  = ~m_i[MW-1] & lz_zero;
        // Negative or zero biased exponent would need a subnormal; flush instead.
        flush_n = ~zero_n & (exp_n[XW-1] | (exp_n == '0));
    end

    logic          s1, nan1, inf1, zero1, flush1;
    logic [XW-1:0] exp1;
    logic [NW-1:0] mant1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            s1     <= 1'b0;
            exp1   <= '0;
            mant1  <= '0;
            nan1   <= 1'b0;
            inf1   <= 1'b0;
            zero1  <= 1'b0;
            flush1 <= 1'b0;
        end else if (en1) begin
            v1 <= valid_i;
            if (valid_i) begin
                s1     <= s_i;
                exp1   <= exp_n;
                mant1  <= mant_n;
                nan1   <= nan_i;
                inf1   <= inf_i;
                zero1  <= zero_n;
                flush1 <= flush_n;
            end
        end
    end

    // ---------------- stage 2: round and pack ----------------
    logic [M-1:0]  frac1;
    logic          g1, r1, st1, grs1, round_up;
    logic [M:0]    frac_sum;
    logic [XW-1:0] exp_r;

    assign frac1    = mant1[NW-2:3];
    assign g1       = mant1[2];
    assign r1       = mant1[1];
    assign st1      = mant1[0];
    assign grs1     = g1 | r1 | st1;
    assign round_up = g1 & (r1 | st1 | frac1[0]);
    assign frac_sum = {1'b0, frac1} + {{M{1'b0}}, round_up};
    // A carry out of the fraction leaves it all zeros, so only the exponent bumps.
    assign exp_r    = exp1 + {{(XW-1){1'b0}}, frac_sum[M]};

    logic         s_n, ovf_n, unf_n, inx_n;
    logic [E-1:0] e_n;
    logic [M-1:0] m_n;

    always_comb begin
        s_n   = s1;
        e_n   = '0;
        m_n   = '0;
        ovf_n = 1'b0;
        unf_n = 1'b0;
        inx_n = 1'b0;
        if (nan1) begin
            s_n = 1'b0;
            e_n = EXP_ONES;
            m_n = QNAN;
        end else if (inf1) begin
            e_n = EXP_ONES;
        end else if (zero1) begin
            e_n = '0;
        end else if (flush1) begin
            unf_n = 1'b1;
            inx_n = grs1;
        end else if (exp_r >= EXP_LIM) begin
            e_n   = EXP_ONES;
            ovf_n = 1'b1;
            inx_n = 1'b1;
        end else begin
            e_n   = exp_r[E-1:0];
            m_n   = frac_sum[M-1:0];
            inx_n = grs1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o     <= 1'b0;
            s_o         <= 1'b0;
            e_o         <= '0;
            m_o         <= '0;
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
            inexact_o   <= 1'b0;
        end else if (en2) begin
            valid_o <= v1;
            if (v1) begin
                s_o         <= s_n;
                e_o         <= e_n;
                m_o         <= m_n;
                overflow_o  <= ovf_n;
                underflow_o <= unf_n;
                inexact_o   <= inx_n;
            end
        end
    end

    // ---------------- checks ----------------
    a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
        valid_o |-> !$isunknown({s_o, e_o, m_o, overflow_o, underflow_o, inexact_o}));

    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
        (valid_o && !ready_i) |=> (valid_o &&
            $stable({s_o, e_o, m_o, overflow_o, underflow_o, inexact_o})));

    a_nan_inf: assert property (@(posedge clk) disable iff (!rst_n)
        !(nan_i && inf_i));

endmodule
